// File: rtl/lms_serial_adapt.sv
// lms_serial_adapt: serial LMS adaptive FIR built around one time-multiplexed MAC.
// Each accepted sample pair runs FILTER (TAPS cycles), CALC, then optionally
// UPDATE (TAPS cycles), and finally DONE, where y_out/e_out are published.
// Optional build macro LMS_LEAKAGE_EN adds w >>> LEAK_SHIFT leakage to the update.
// Handshake: a sample is accepted on a rising clk edge where in_valid && in_ready;
// in_ready is high only in IDLE with clear_w low, and clear_w wins over in_valid.
module lms_serial_adapt #(
   parameter int DATA_W     = 16,
   parameter int TAPS       = 8,
   parameter int LEAK_SHIFT = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] x_in,
   input  logic signed [DATA_W-1:0] d_in,
   input  logic signed [DATA_W-1:0] mu,
   input  logic                     adapt_en,
   input  logic                     clear_w,
   output logic signed [DATA_W-1:0] y_out,
   output logic signed [DATA_W-1:0] e_out,
   output logic                     out_valid,
   output logic [2:0]               state_dbg
);

   localparam int LOG2T = $clog2(TAPS);
   localparam int ACC_W = 2*DATA_W + LOG2T;
   localparam int MW    = 2*DATA_W;
   localparam int PW    = 3*DATA_W;
   localparam int WW    = 3*DATA_W + LOG2T + 2;

`ifdef LMS_LEAKAGE_EN
   localparam bit LEAK_ON = 1'b1;
`else
   localparam bit LEAK_ON = 1'b0;
`endif

   localparam logic signed [WW-1:0] SMAX = (WW'(1) <<< (DATA_W-1)) - WW'(1);
   localparam logic signed [WW-1:0] SMIN = -SMAX - WW'(1);
   localparam logic signed [WW-1:0] ZERO = '0;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FILTER = 3'd1,
      CALC   = 3'd2,
      UPDATE = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t                     state;
   logic [LOG2T-1:0]           k;
   logic signed [DATA_W-1:0]   x [TAPS];
   logic signed [DATA_W-1:0]   w [TAPS];
   logic signed [ACC_W-1:0]    acc;
   logic signed [DATA_W-1:0]   d_r, mu_r, y_r, e_r;
   logic                       adapt_r;

   // Clamp a wide signed value into the Q1.(DATA_W-1) range.
   function automatic logic signed [DATA_W-1:0] sat(input logic signed [WW-1:0] v);
      if (v > SMAX)      return SMAX[DATA_W-1:0];
      else if (v < SMIN) return SMIN[DATA_W-1:0];
      else               return v[DATA_W-1:0];
   endfunction

   // Datapath around the shared tap k.
   logic signed [DATA_W-1:0] w_sel, x_sel, leak, y_c, e_c, w_new;
   logic signed [MW-1:0]     mac_prod, mu_e;
   logic signed [ACC_W-1:0]  acc_sh;
   logic signed [PW-1:0]     mex, upd;
   logic signed [WW-1:0]     w_sum;
   logic                     last_k;

   assign w_sel    = w[k];
   assign x_sel    = x[k];
   assign last_k   = (k == LOG2T'(TAPS-1));
   assign mac_prod = MW'(w_sel) * MW'(x_sel);
   assign acc_sh   = acc >>> (DATA_W-1);
   assign y_c      = sat(WW'(acc_sh));
   assign e_c      = sat(WW'(d_r) - WW'(y_c));
   assign mu_e     = MW'(mu_r) * MW'(e_r);
   assign mex      = PW'(mu_e) * PW'(x_sel);
   assign upd      = mex >>> (2*(DATA_W-1));
   assign leak     = w_sel >>> LEAK_SHIFT;
   assign w_sum    = WW'(w_sel) - (LEAK_ON ? WW'(leak) : ZERO) + WW'(upd);
   assign w_new    = sat(w_sum);

   assign in_ready  = (state == IDLE) && !clear_w;
   assign state_dbg = state;

   // Control FSM together with the delay line, accumulator, weights and outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         k         <= '0;
         acc       <= '0;
         d_r       <= '0;
         mu_r      <= '0;
         y_r       <= '0;
         e_r       <= '0;
         adapt_r   <= 1'b0;
         y_out     <= '0;
         e_out     <= '0;
         out_valid <= 1'b0;
         for (int i = 0; i < TAPS; i++) begin
            x[i] <= '0;
            w[i] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (clear_w) begin
                  for (int i = 0; i < TAPS; i++) w[i] <= '0;
               end else if (in_valid) begin
                  for (int i = TAPS-1; i > 0; i--) x[i] <= x[i-1];
                  x[0]    <= x_in;
                  d_r     <= d_in;
                  mu_r    <= mu;
                  adapt_r <= adapt_en;
                  acc     <= '0;
                  k       <= '0;
                  state   <= FILTER;
               end
            end
            FILTER: begin
               acc <= acc + ACC_W'(mac_prod);
               k   <= k + LOG2T'(1);
               if (last_k) state <= CALC;
            end
            CALC: begin
               y_r <= y_c;
               e_r <= e_c;
               k   <= '0;
               if (adapt_r) begin
                  state <= UPDATE;
               end else begin
                  y_out     <= y_c;
                  e_out     <= e_c;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            UPDATE: begin
               w[k] <= w_new;
               k    <= k + LOG2T'(1);
               if (last_k) begin
                  y_out     <= y_r;
                  e_out     <= e_r;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
